// File: rtl/traffic_sensor_frontend_if.sv
// Detector/green inputs and presence/long-green outputs of the traffic sensor frontend.
// TL_SENSOR_CONFLICT_FLAG_EN adds the sticky conflict_err output.
interface traffic_sensor_frontend_if;
   logic car_a_raw;
   logic car_b_raw;
   logic green_a;
   logic green_b;
   logic TA;
   logic TB;
   logic TaL;
   logic TbL;
`ifdef TL_SENSOR_CONFLICT_FLAG_EN
   logic conflict_err;
`endif

   modport master (
      output car_a_raw, car_b_raw, green_a, green_b,
      input  TA, TB, TaL, TbL
`ifdef TL_SENSOR_CONFLICT_FLAG_EN
      , input conflict_err
`endif
   );

   modport slave (
      input  car_a_raw, car_b_raw, green_a, green_b,
      output TA, TB, TaL, TbL
`ifdef TL_SENSOR_CONFLICT_FLAG_EN
      , output conflict_err
`endif
   );
endinterface

// File: rtl/traffic_sensor_frontend.sv
// Sync+debounce of vehicle detectors into TA/TB (DEB_CYCLES+2 edges after a stable change) and long-green pulses TaL/TbL
// every LONG_CYCLES held-green edges; no backpressure. TL_SENSOR_CONFLICT_FLAG_EN adds a sticky conflict_err flag.
module traffic_sensor_frontend #(
   parameter int DEB_CYCLES  = 4,
   parameter int LONG_CYCLES = 16,
   parameter int CNT_W       = 8
) (
   input logic                      clk,
   input logic                      rst,
   traffic_sensor_frontend_if.slave bus
);
   localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

   logic [1:0]       raw;
   logic [1:0]       grn;
   logic [1:0]       s1;
   logic [1:0]       s2;
   logic [1:0]       pres;
   logic [1:0]       pulse;
   logic [CNT_W-1:0] deb_cnt [2];
   logic [CNT_W-1:0] timer   [2];
   logic             conflict;

   // Index 0 is road A, index 1 is road B throughout.
   assign raw      = {bus.car_b_raw, bus.car_a_raw};
   assign grn      = {bus.green_b, bus.green_a};
   assign conflict = &grn;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1    <= '0;
         s2    <= '0;
         pres  <= '0;
         pulse <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i] <= '0;
            timer[i]   <= '0;
         end
      end else begin
         s1 <= raw;
         s2 <= s1;
         for (int i = 0; i < 2; i++) begin
            // Any sample agreeing with the current level restarts the count.
            if (s2[i] == pres[i]) begin
               deb_cnt[i] <= '0;
            end else if (deb_cnt[i] == DEB_MAX) begin
               pres[i]    <= s2[i];
               deb_cnt[i] <= '0;
            end else begin
               deb_cnt[i] <= deb_cnt[i] + ONE;
            end

            // Both greens at once is illegal: hold both timers cleared.
            if (grn[i] && !conflict) begin
               if (timer[i] == LONG_MAX) begin
                  pulse[i] <= 1'b1;
                  timer[i] <= '0;
               end else begin
                  pulse[i] <= 1'b0;
                  timer[i] <= timer[i] + ONE;
               end
            end else begin
               pulse[i] <= 1'b0;
               timer[i] <= '0;
            end
         end
      end
   end

   assign bus.TA  = pres[0];
   assign bus.TB  = pres[1];
   assign bus.TaL = pulse[0];
   assign bus.TbL = pulse[1];

`ifdef TL_SENSOR_CONFLICT_FLAG_EN
   logic conflict_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         conflict_q <= 1'b0;
      end else if (conflict) begin
         conflict_q <= 1'b1;
      end
   end

   assign bus.conflict_err = conflict_q;
`endif
endmodule

// File: tb/tb_traffic_sensor_frontend.sv
// Directed and random stimulus for traffic_sensor_frontend, checked every cycle against a sample-window/run-length model.
module tb_traffic_sensor_frontend;
   localparam int DEB  = 4;
   localparam int LONG = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;
   int   cyc      = 0;

   traffic_sensor_frontend_if bus ();

   traffic_sensor_frontend #(
      .DEB_CYCLES (DEB),
      .LONG_CYCLES(LONG),
      .CNT_W      (8)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference state: raw samples since reset, debounce samples seen, green run lengths.
   bit rq [2][$];
   bit dq [2][$];
   bit ta_m [2];
   int run  [2];
   bit pl_m [2];
   bit cflag;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
   endtask

   task automatic model_edge();
      bit raw [2];
      bit grn [2];
      raw[0] = bus.car_a_raw;
      raw[1] = bus.car_b_raw;
      grn[0] = bus.green_a;
      grn[1] = bus.green_b;
      if (rst) begin
         for (int i = 0; i < 2; i++) begin
            rq[i].delete();
            dq[i].delete();
            ta_m[i] = 1'b0;
            run[i]  = 0;
            pl_m[i] = 1'b0;
         end
         cflag = 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            bit d;
            bit all_diff;
            // Two-flop delay: the decision at this edge sees the raw value from two edges ago.
            rq[i].push_back(raw[i]);
            d = (rq[i].size() >= 3) ? rq[i][rq[i].size() - 3] : 1'b0;
            dq[i].push_back(d);
            if (dq[i].size() >= DEB) begin
               all_diff = 1'b1;
               for (int k = 1; k <= DEB; k++)
                  if (dq[i][dq[i].size() - k] == ta_m[i]) all_diff = 1'b0;
               if (all_diff) ta_m[i] = ~ta_m[i];
            end
            if (grn[i] && !grn[1 - i]) run[i]++;
            else run[i] = 0;
            pl_m[i] = (run[i] > 0) && (run[i] % LONG == 0);
         end
         if (grn[0] && grn[1]) cflag = 1'b1;
      end
   endtask

   task automatic cycle(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_edge();
         @(negedge clk);
         cyc++;
         chk("TA",  bus.TA,  ta_m[0]);
         chk("TB",  bus.TB,  ta_m[1]);
         chk("TaL", bus.TaL, pl_m[0]);
         chk("TbL", bus.TbL, pl_m[1]);
`ifdef TL_SENSOR_CONFLICT_FLAG_EN
         chk("conflict_err", bus.conflict_err, cflag);
`endif
      end
   endtask

   task automatic drive(input bit a, input bit b, input bit ga, input bit gb);
      bus.car_a_raw = a;
      bus.car_b_raw = b;
      bus.green_a   = ga;
      bus.green_b   = gb;
   endtask

   initial begin
      int hold [4];
      bit val  [4];
      int gmode;

      drive(0, 0, 0, 0);
      rst = 1'b1;
      cycle(2);
      rst = 1'b0;
      cycle(20);

      // Debounce latency on A, rise then fall.
      drive(1, 0, 0, 0); cycle(12);
      drive(0, 0, 0, 0); cycle(12);

      // Glitch rejection on B: 3 high; then 3 high, 1 low, 4+ high.
      drive(0, 1, 0, 0); cycle(3);
      drive(0, 0, 0, 0); cycle(8);
      drive(0, 1, 0, 0); cycle(3);
      drive(0, 0, 0, 0); cycle(1);
      drive(0, 1, 0, 0); cycle(12);
      drive(0, 0, 0, 0); cycle(10);

      // Long pulses while A green is held, then drop mid-count and re-raise.
      drive(0, 0, 1, 0); cycle(40);
      drive(0, 0, 0, 0); cycle(2);
      drive(0, 0, 1, 0); cycle(10);
      drive(0, 0, 0, 0); cycle(3);
      drive(0, 0, 1, 0); cycle(20);
      drive(0, 0, 0, 1); cycle(20);

      // Conflict, then reset clears any sticky flag.
      drive(0, 0, 1, 1); cycle(20);
      drive(0, 0, 0, 0); cycle(3);
      rst = 1'b1; cycle(1);
      rst = 1'b0; cycle(3);

      for (int s = 0; s < 4; s++) begin
         hold[s] = 0;
         val[s]  = 1'b0;
      end
      gmode = 0;
      for (int n = 0; n < 3000; n++) begin
         for (int s = 0; s < 2; s++) begin
            if (hold[s] == 0) begin
               val[s]  = 1'($urandom_range(0, 1));
               hold[s] = $urandom_range(1, 2 * DEB + 2);
            end
            hold[s]--;
         end
         if (hold[2] == 0) begin
            gmode   = $urandom_range(0, 9);
            hold[2] = $urandom_range(1, 2 * LONG + 4);
         end
         hold[2]--;
         val[2] = (gmode >= 2 && gmode <= 5) || gmode == 9;
         val[3] = (gmode >= 6);
         rst = ($urandom_range(0, 299) == 0);
         drive(val[0], val[1], val[2], val[3]);
         cycle(1);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
